// File: rtl/instruction_fetch_unit_pkg.sv
// Shared pipeline definitions for the fetch front end: branch-select encodings,
// the NOP bubble word and the fetch state type.
package instruction_fetch_unit_pkg;

  localparam logic [1:0] BS_SEQ  = 2'd0;
  localparam logic [1:0] BS_COND = 2'd1;
  localparam logic [1:0] BS_JMR  = 2'd2;
  localparam logic [1:0] BS_JUMP = 2'd3;

  localparam logic [31:0] NOP_INSTR = 32'h0000_0000;

  typedef enum logic {
    StFetch,
    StHold
  } fetch_state_e;

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Instruction-memory request/acknowledge bus between the fetch unit (master)
// and instruction memory (slave).
interface instruction_fetch_unit_if #(
  parameter int unsigned PC_W = 32
);

  logic            req;
  logic [PC_W-1:0] addr;
  logic [31:0]     rdata;
  logic            ack;

  modport master (
    output req,
    output addr,
    input  rdata,
    input  ack
  );

  modport slave (
    input  req,
    input  addr,
    output rdata,
    output ack
  );

endinterface

// File: rtl/instruction_fetch_unit_fetch_redirect_logic.sv
// Branch/jump resolution from execute-stage results: decides whether the PC is
// redirected and where to.
module fetch_redirect_logic
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned PC_W = 32
) (
  input  logic [1:0]      ex_bs,
  input  logic            ex_ps,
  input  logic            ex_z,
  input  logic [PC_W-1:0] ex_br_addr,
  input  logic [PC_W-1:0] ex_reg_addr,
  output logic            taken,
  output logic [PC_W-1:0] target
);

  always_comb begin
    taken  = 1'b0;
    target = ex_br_addr;
    unique case (ex_bs)
      BS_COND: taken = ex_z ^ ex_ps;
      BS_JMR: begin
        taken  = 1'b1;
        target = ex_reg_addr;
      end
      BS_JUMP: taken = 1'b1;
      default: taken = 1'b0;
    endcase
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Fetch stage: owns the PC, fetches words over the imem handshake and loads the
// IR register, injecting one NOP bubble on every taken redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned    PC_W     = 32,
  parameter logic [PC_W-1:0] RESET_PC = '0
) (
  input  logic                       clk,
  input  logic                       rst,
  instruction_fetch_unit_if.master   imem,
  input  logic                       stall,
  input  logic [1:0]                 ex_bs,
  input  logic                       ex_ps,
  input  logic                       ex_z,
  input  logic [PC_W-1:0]            ex_br_addr,
  input  logic [PC_W-1:0]            ex_reg_addr,
  output logic [31:0]                ir,
  output logic                       ir_valid,
  output logic [PC_W-1:0]            ir_pc1
);

  localparam logic [PC_W-1:0] PcOne = PC_W'(1);

  fetch_state_e    r_state_q, r_state_d;
  logic [PC_W-1:0] r_pc_q, r_pc_d;
  logic [31:0]     r_ir_q, r_ir_d;
  logic            r_valid_q, r_valid_d;
  logic [PC_W-1:0] r_pc1_q, r_pc1_d;
  logic [31:0]     r_hold_q, r_hold_d;

  logic            w_taken;
  logic [PC_W-1:0] w_target;
  logic [PC_W-1:0] w_pc_inc;

  fetch_redirect_logic #(
    .PC_W (PC_W)
  ) u_redirect (
    .ex_bs       (ex_bs),
    .ex_ps       (ex_ps),
    .ex_z        (ex_z),
    .ex_br_addr  (ex_br_addr),
    .ex_reg_addr (ex_reg_addr),
    .taken       (w_taken),
    .target      (w_target)
  );

  assign w_pc_inc = r_pc_q + PcOne;

  // Request is gated by reset so it is low during the reset cycle itself.
  assign imem.req  = (r_state_q == StFetch) && !rst;
  assign imem.addr = r_pc_q;

  always_comb begin
    r_state_d = r_state_q;
    r_pc_d    = r_pc_q;
    r_ir_d    = r_ir_q;
    r_valid_d = r_valid_q;
    r_pc1_d   = r_pc1_q;
    r_hold_d  = r_hold_q;

    if (w_taken) begin
      // Redirect wins over stall, ack and any held word.
      r_pc_d    = w_target;
      r_ir_d    = NOP_INSTR;
      r_valid_d = 1'b0;
      r_state_d = StFetch;
    end else begin
      unique case (r_state_q)
        StFetch: begin
          if (imem.ack && !stall) begin
            r_ir_d    = imem.rdata;
            r_valid_d = 1'b1;
            r_pc1_d   = w_pc_inc;
            r_pc_d    = w_pc_inc;
          end else if (imem.ack && stall) begin
            r_hold_d  = imem.rdata;
            r_pc_d    = w_pc_inc;
            r_state_d = StHold;
          end else if (!stall) begin
            r_ir_d    = NOP_INSTR;
            r_valid_d = 1'b0;
          end
        end
        StHold: begin
          if (!stall) begin
            r_ir_d    = r_hold_q;
            r_valid_d = 1'b1;
            r_pc1_d   = r_pc_q;
            r_state_d = StFetch;
          end
        end
        default: r_state_d = StFetch;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state_q <= StFetch;
      r_pc_q    <= RESET_PC;
      r_ir_q    <= NOP_INSTR;
      r_valid_q <= 1'b0;
      r_pc1_q   <= '0;
      r_hold_q  <= '0;
    end else begin
      r_state_q <= r_state_d;
      r_pc_q    <= r_pc_d;
      r_ir_q    <= r_ir_d;
      r_valid_q <= r_valid_d;
      r_pc1_q   <= r_pc1_d;
      r_hold_q  <= r_hold_d;
    end
  end

  assign ir       = r_ir_q;
  assign ir_valid = r_valid_q;
  assign ir_pc1   = r_pc1_q;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed by
// randomized ack/stall/branch traffic against an architectural reference model.
module tb_instruction_fetch_unit;

  localparam int unsigned PC_W   = 32;
  localparam logic [31:0] RST_PC = 32'h10;

  logic        clk = 1'b0;
  logic        rst;
  logic        stall;
  logic [1:0]  ex_bs;
  logic        ex_ps;
  logic        ex_z;
  logic [31:0] ex_br_addr;
  logic [31:0] ex_reg_addr;
  logic [31:0] ir;
  logic        ir_valid;
  logic [31:0] ir_pc1;

  instruction_fetch_unit_if #(.PC_W(PC_W)) imem_bus ();

  instruction_fetch_unit #(
    .PC_W     (PC_W),
    .RESET_PC (RST_PC)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .imem        (imem_bus),
    .stall       (stall),
    .ex_bs       (ex_bs),
    .ex_ps       (ex_ps),
    .ex_z        (ex_z),
    .ex_br_addr  (ex_br_addr),
    .ex_reg_addr (ex_reg_addr),
    .ir          (ir),
    .ir_valid    (ir_valid),
    .ir_pc1      (ir_pc1)
  );

  always #5 clk = ~clk;

  int unsigned n_checks = 0;
  int unsigned n_errors = 0;

  // Architectural model: pc, IR contents, and at most one fetched-but-undelivered word.
  logic [31:0] m_pc;
  logic [31:0] m_ir;
  logic        m_valid;
  logic [31:0] m_pc1;
  logic [31:0] m_held[$];

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    if (a == 32'h8) return 32'hABCD_0001;
    return {a[15:0] ^ 16'hC3A5, a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
    end
  endtask

  task automatic cycle(input logic r, input logic a, input logic s, input logic [1:0] bs,
                       input logic ps_i, input logic z_i, input logic [31:0] br_i,
                       input logic [31:0] rg_i);
    logic        req_e;
    logic        ack_e;
    logic        tk;
    logic [31:0] tgt;
    req_e = !r && (m_held.size() == 0);
    ack_e = a && req_e;
    rst         = r;
    stall       = s;
    ex_bs       = bs;
    ex_ps       = ps_i;
    ex_z        = z_i;
    ex_br_addr  = br_i;
    ex_reg_addr = rg_i;
    imem_bus.ack   = ack_e;
    imem_bus.rdata = ack_e ? mem_word(m_pc) : $urandom;
    #1;
    check_eq("imem_req", {31'b0, imem_bus.req}, {31'b0, req_e});
    if (req_e) check_eq("imem_addr", imem_bus.addr, m_pc);

    tk  = (bs == 2'd1 && (z_i != ps_i)) || bs == 2'd2 || bs == 2'd3;
    tgt = (bs == 2'd2) ? rg_i : br_i;
    if (r) begin
      m_pc = RST_PC; m_ir = 32'h0; m_valid = 1'b0; m_pc1 = 32'h0;
      m_held.delete();
    end else if (tk) begin
      m_pc = tgt; m_ir = 32'h0; m_valid = 1'b0;
      m_held.delete();
    end else if (m_held.size() != 0) begin
      if (!s) begin
        m_ir = m_held.pop_front(); m_valid = 1'b1; m_pc1 = m_pc;
      end
    end else if (ack_e) begin
      if (s) m_held.push_back(mem_word(m_pc));
      else begin
        m_ir = mem_word(m_pc); m_valid = 1'b1; m_pc1 = m_pc + 32'd1;
      end
      m_pc = m_pc + 32'd1;
    end else if (!s) begin
      m_ir = 32'h0; m_valid = 1'b0;
    end

    @(posedge clk);
    #1;
    check_eq("ir", ir, m_ir);
    check_eq("ir_valid", {31'b0, ir_valid}, {31'b0, m_valid});
    check_eq("ir_pc1", ir_pc1, m_pc1);
    @(negedge clk);
  endtask

  initial begin
    int unsigned bs_r;
    logic [31:0] br_r;
    m_pc = RST_PC; m_ir = 32'h0; m_valid = 1'b0; m_pc1 = 32'h0;

    // Reset, then back-to-back fetches from 0x10.
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 1, 0, 0, 0, 0, 0, 0);
    repeat (4) cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // Jump to 0x5, ack withheld for 3 cycles, then delivered.
    cycle(0, 0, 0, 3, 0, 0, 32'h5, 0);
    repeat (3) cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // Stall coinciding with the ack of 0xABCD0001 at 0x8.
    cycle(0, 0, 0, 3, 0, 0, 32'h8, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // Conditional branch: taken with z=1/ps=0 (ack dropped), not taken with z=0/ps=0,
    // taken with z=0/ps=1.
    cycle(0, 1, 0, 1, 0, 1, 32'h40, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 1, 0, 0, 32'h77, 0);
    cycle(0, 1, 0, 1, 1, 0, 32'h60, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // JMR while held in HOLD with stall asserted.
    cycle(0, 1, 1, 0, 0, 0, 0, 0);
    cycle(0, 0, 1, 2, 0, 0, 32'h999, 32'h123);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // PC wrap from all-ones.
    cycle(0, 0, 0, 3, 0, 0, 32'hFFFF_FFFF, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    // Reset with a request outstanding.
    cycle(0, 0, 0, 0, 0, 0, 0, 0);
    cycle(1, 0, 0, 0, 0, 0, 0, 0);
    cycle(0, 1, 0, 0, 0, 0, 0, 0);

    for (int i = 0; i < 1500; i++) begin
      bs_r = $urandom_range(0, 11);
      if (bs_r > 3) bs_r = 0;
      br_r = ($urandom_range(0, 15) == 0) ? 32'hFFFF_FFFF : $urandom;
      cycle(($urandom_range(0, 199) == 0), ($urandom_range(0, 3) != 0),
            ($urandom_range(0, 4) == 0), bs_r[1:0], 1'($urandom_range(0, 1)),
            1'($urandom_range(0, 1)), br_r, $urandom);
    end

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
